// File: rtl/inverter_pkg.sv
// Shared defaults, ID width helper and FSM state encoding for the inverter arbiter.
package inverter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 32;
  localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Keeps the ID port at least one bit wide when only one requester exists.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inverter.sv
// Datapath: result = all-ones minus operand (bitwise NOT).
// Combinational, no backpressure.
module inverter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = {WIDTH{1'b1}} - din;

endmodule

// File: rtl/inverter_arbiter.sv
// Round-robin arbiter feeding one shared inverter; result registered, 1-cycle latency.
// Backpressure: no grant while a result is held and resp_ready is low.
module inverter_arbiter
  import inverter_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int WIDTH   = WIDTH_DEF,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  output logic [ID_W-1:0]          resp_id,
  input  logic                     resp_ready,
  output logic [15:0]              op_count
);

  state_t          state_q;
  state_t          state_d;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic            grant_found;
  logic            accept;
  logic            xfer;
  logic            resp_hs;
  logic [WIDTH-1:0] op_sel;
  logic [WIDTH-1:0] op_inv;

  // First valid requester after the last granted one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept  = !reset && ((state_q == IDLE) || resp_ready);
  assign xfer    = accept && grant_found;
  assign resp_hs = resp_valid && resp_ready;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        op_sel = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  inverter #(
    .WIDTH (WIDTH)
  ) u_inverter (
    .din  (op_sel),
    .dout (op_inv)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A transfer while HOLD can only happen alongside a handshake, so HOLD stays HOLD.
  always_comb begin
    state_d    = state_q;
    resp_valid = (state_q == HOLD);
    case (state_q)
      IDLE:    if (xfer) state_d = HOLD;
      HOLD:    if (resp_ready && !xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data  <= '0;
      resp_id    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      op_count   <= '0;
    end else begin
      if (xfer) begin
        resp_data  <= op_inv;
        resp_id    <= grant_idx;
        last_grant <= grant_idx;
      end
      if (resp_hs) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule
